// File: rtl/bus_condition_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_condition_monitor_pkg
// Description : Shared definitions for the bus condition monitor: controller
//               state encoding, default counter width and a state helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_condition_monitor_pkg;

    // Default width of the timing inputs and of every hold counter
    localparam int unsigned c_cntr_w_default = 20;

    // Controller states
    typedef enum logic [2:0] {
        ST_DISABLED   = 3'd0,
        ST_WAIT_FREE  = 3'd1,
        ST_FREE       = 3'd2,
        ST_START_CHK  = 3'd3,
        ST_BUSY       = 3'd4,
        ST_RSTART_CHK = 3'd5
    } state_t;

    // The bus counts as occupied from the first START qualification onwards
    function automatic logic is_busy_state(input state_t st);
        return (st == ST_START_CHK) || (st == ST_BUSY) || (st == ST_RSTART_CHK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_condition_monitor_hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : bus_condition_monitor_hold_timer
// Description : Saturating hold counter. Clear has priority, the count only
//               advances while below the target, and done is a live >=
//               compare against the (possibly changing) target.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_condition_monitor_hold_timer
    import bus_condition_monitor_pkg::*;
#(
    parameter int unsigned CNTR_W = c_cntr_w_default
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              enable_i,
    input  logic [CNTR_W-1:0] target_i,
    output logic              done_o
);

    logic [CNTR_W-1:0] count_d;
    logic [CNTR_W-1:0] count_q;

    // Next count: clear wins, otherwise step only while still short of target
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q < target_i)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q >= target_i);

endmodule
`default_nettype wire

// File: rtl/bus_condition_monitor.sv
`default_nettype none
// ============================================================================
// Module      : bus_condition_monitor
// Description : I2C-style bus condition monitor. Detects START, repeated
//               START and STOP on pre-synchronized SCL/SDA, qualifies START
//               hold time, tracks bus busy/free, and optionally bus idle.
//               Optional feature macro: BUS_MON_IDLE_DET_EN (bus-idle timer).
// Revision    : 1.0 - initial release
// ============================================================================
module bus_condition_monitor
    import bus_condition_monitor_pkg::*;
#(
    parameter int unsigned CNTR_W = c_cntr_w_default
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic              scl_i,
    input  logic              sda_i,
    input  logic [CNTR_W-1:0] t_hd_sta_i,
    input  logic [CNTR_W-1:0] t_bus_free_i,
    input  logic [CNTR_W-1:0] t_idle_i,
    output logic              start_det_o,
    output logic              rstart_det_o,
    output logic              stop_det_o,
    output logic              hd_sta_viol_o,
    output logic              bus_busy_o,
    output logic              bus_free_o,
    output logic              bus_idle_o
);

    state_t state_d, state_q;
    logic   scl_q, sda_q;
    logic   start_det_d, start_det_q;
    logic   rstart_det_d, rstart_det_q;
    logic   stop_det_d, stop_det_q;
    logic   hd_sta_viol_d, hd_sta_viol_q;
    logic   bus_busy_d, bus_busy_q;
    logic   bus_free_d, bus_free_q;

    logic   w_lines_high;
    logic   w_sda_fall;
    logic   w_sda_rise;
    logic   w_hold_clr;
    logic   w_hold_en;
    logic   w_hold_done;

    // SDA edges only count while SCL is high on both samples, so an SDA
    // change that coincides with an SCL transition is never a condition.
    assign w_lines_high = scl_i & sda_i;
    assign w_sda_fall   = scl_q & scl_i &  sda_q & ~sda_i;
    assign w_sda_rise   = scl_q & scl_i & ~sda_q &  sda_i;

    // Controller next-state, pulse and hold-timer control
    always_comb begin
        state_d       = state_q;
        start_det_d   = 1'b0;
        rstart_det_d  = 1'b0;
        stop_det_d    = 1'b0;
        hd_sta_viol_d = 1'b0;
        w_hold_clr    = 1'b0;
        w_hold_en     = 1'b0;

        if (!enable_i) begin
            state_d = ST_DISABLED;
        end else begin
            case (state_q)
                ST_DISABLED: begin
                    state_d = ST_WAIT_FREE;
                end
                ST_WAIT_FREE: begin
                    w_hold_en = 1'b1;
                    if (!w_lines_high) begin
                        w_hold_clr = 1'b1;
                    end else if (w_hold_done) begin
                        state_d = ST_FREE;
                    end
                end
                ST_FREE: begin
                    if (w_sda_fall) begin
                        state_d = ST_START_CHK;
                    end
                end
                ST_START_CHK, ST_RSTART_CHK: begin
                    w_hold_en = 1'b1;
                    if (sda_i) begin
                        // SDA released before hold completed: not a condition
                        state_d = (state_q == ST_START_CHK) ? ST_FREE : ST_BUSY;
                    end else if (!scl_i || w_hold_done) begin
                        // SCL dropping early still starts the transfer, but flagged
                        state_d       = ST_BUSY;
                        hd_sta_viol_d = ~scl_i;
                        start_det_d   = (state_q == ST_START_CHK);
                        rstart_det_d  = (state_q == ST_RSTART_CHK);
                    end
                end
                ST_BUSY: begin
                    if (w_sda_fall) begin
                        state_d = ST_RSTART_CHK;
                    end else if (w_sda_rise) begin
                        state_d    = ST_WAIT_FREE;
                        stop_det_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_DISABLED;
                end
            endcase
        end

        // Every hold measurement starts from zero on state entry
        if (state_d != state_q) begin
            w_hold_clr = 1'b1;
        end

        bus_busy_d = is_busy_state(state_d);
        bus_free_d = (state_d == ST_FREE);
    end

    // Controller state, line history and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_DISABLED;
            scl_q         <= 1'b1;
            sda_q         <= 1'b1;
            start_det_q   <= 1'b0;
            rstart_det_q  <= 1'b0;
            stop_det_q    <= 1'b0;
            hd_sta_viol_q <= 1'b0;
            bus_busy_q    <= 1'b0;
            bus_free_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            scl_q         <= scl_i;
            sda_q         <= sda_i;
            start_det_q   <= start_det_d;
            rstart_det_q  <= rstart_det_d;
            stop_det_q    <= stop_det_d;
            hd_sta_viol_q <= hd_sta_viol_d;
            bus_busy_q    <= bus_busy_d;
            bus_free_q    <= bus_free_d;
        end
    end

    // Shared timer for bus-free and START hold measurements
    bus_condition_monitor_hold_timer #(
        .CNTR_W   (CNTR_W)
    ) u_hold_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (w_hold_clr),
        .enable_i (w_hold_en),
        .target_i (state_q == ST_WAIT_FREE ? t_bus_free_i : t_hd_sta_i),
        .done_o   (w_hold_done)
    );

`ifdef BUS_MON_IDLE_DET_EN
    logic w_idle_clr;
    logic w_idle_done;
    logic bus_idle_d, bus_idle_q;

    // Idle time accumulates only while sitting in FREE with both lines high
    assign w_idle_clr = (state_q != ST_FREE) | ~w_lines_high;
    assign bus_idle_d = (state_d == ST_FREE) & w_idle_done;

    bus_condition_monitor_hold_timer #(
        .CNTR_W   (CNTR_W)
    ) u_idle_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (w_idle_clr),
        .enable_i (1'b1),
        .target_i (t_idle_i),
        .done_o   (w_idle_done)
    );

    // Registered idle flag, dropped as soon as the controller leaves FREE
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus_idle_q <= 1'b0;
        end else begin
            bus_idle_q <= bus_idle_d;
        end
    end

    assign bus_idle_o = bus_idle_q;
`else
    // Idle detection absent: threshold input intentionally has no load
    logic w_unused_t_idle;
    assign w_unused_t_idle = ^t_idle_i;
    assign bus_idle_o      = 1'b0;
`endif

    assign start_det_o   = start_det_q;
    assign rstart_det_o  = rstart_det_q;
    assign stop_det_o    = stop_det_q;
    assign hd_sta_viol_o = hd_sta_viol_q;
    assign bus_busy_o    = bus_busy_q;
    assign bus_free_o    = bus_free_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_condition_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_condition_monitor
// Description : Directed bench for bus_condition_monitor. Stimulus queues the
//               expected pulses and level snapshots by cycle number; a
//               negedge monitor pops and compares them against the outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_condition_monitor;

    localparam int unsigned CNTR_W = 20;
`ifdef BUS_MON_IDLE_DET_EN
    localparam logic c_IDLE_EXP = 1'b1;
`else
    localparam logic c_IDLE_EXP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              enable_i;
    logic              scl_i;
    logic              sda_i;
    logic [CNTR_W-1:0] t_hd_sta_i;
    logic [CNTR_W-1:0] t_bus_free_i;
    logic [CNTR_W-1:0] t_idle_i;
    logic              start_det_o;
    logic              rstart_det_o;
    logic              stop_det_o;
    logic              hd_sta_viol_o;
    logic              bus_busy_o;
    logic              bus_free_o;
    logic              bus_idle_o;

    bus_condition_monitor #(
        .CNTR_W        (CNTR_W)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .enable_i      (enable_i),
        .scl_i         (scl_i),
        .sda_i         (sda_i),
        .t_hd_sta_i    (t_hd_sta_i),
        .t_bus_free_i  (t_bus_free_i),
        .t_idle_i      (t_idle_i),
        .start_det_o   (start_det_o),
        .rstart_det_o  (rstart_det_o),
        .stop_det_o    (stop_det_o),
        .hd_sta_viol_o (hd_sta_viol_o),
        .bus_busy_o    (bus_busy_o),
        .bus_free_o    (bus_free_o),
        .bus_idle_o    (bus_idle_o)
    );

    always #5 clk = ~clk;

    // Cycle n is the interval following the n-th rising edge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse vector order: {start, rstart, stop, viol}
    typedef struct { int cyc; logic [3:0] p; } evt_t;
    typedef struct { int cyc; logic busy; logic free; logic idle; } lvl_t;

    evt_t evt_q[$];
    lvl_t lvl_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic push_evt(input int c, input logic [3:0] p);
        evt_t it;
        int   i;
        it.cyc = c;
        it.p   = p;
        i      = 0;
        while (i < evt_q.size() && evt_q[i].cyc <= c) i++;
        evt_q.insert(i, it);
    endtask

    task automatic push_lvl(input int c, input logic busy, input logic free, input logic idle);
        lvl_t it;
        int   i;
        it.cyc  = c;
        it.busy = busy;
        it.free = free;
        it.idle = idle;
        i       = 0;
        while (i < lvl_q.size() && lvl_q[i].cyc <= c) i++;
        lvl_q.insert(i, it);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    // Monitor: compare outputs mid-cycle against queued expectations
    logic [3:0] mon_p;
    evt_t       mev;
    lvl_t       mlv;
    always @(negedge clk) begin
        if (cyc >= 2) begin
            mon_p = {start_det_o, rstart_det_o, stop_det_o, hd_sta_viol_o};
            while (evt_q.size() > 0 && evt_q[0].cyc < cyc) begin
                mev = evt_q.pop_front();
                n_checks++;
                n_errors++;
                $display("FAIL missed_pulse cyc=%0d got=none required=%b", mev.cyc, mev.p);
            end
            if (mon_p != 4'b0000) begin
                n_checks++;
                if (evt_q.size() == 0 || evt_q[0].cyc != cyc) begin
                    n_errors++;
                    $display("FAIL unexpected_pulse cyc=%0d got=%b required=none", cyc, mon_p);
                end else begin
                    mev = evt_q.pop_front();
                    if (mev.p != mon_p) begin
                        n_errors++;
                        $display("FAIL pulse_value cyc=%0d got=%b required=%b", cyc, mon_p, mev.p);
                    end
                end
            end
            while (lvl_q.size() > 0 && lvl_q[0].cyc < cyc) begin
                mlv = lvl_q.pop_front();
                n_checks++;
                n_errors++;
                $display("FAIL stale_level cyc=%0d not sampled", mlv.cyc);
            end
            if (lvl_q.size() > 0 && lvl_q[0].cyc == cyc) begin
                mlv = lvl_q.pop_front();
                n_checks++;
                if ({bus_busy_o, bus_free_o, bus_idle_o} !== {mlv.busy, mlv.free, mlv.idle}) begin
                    n_errors++;
                    $display("FAIL levels cyc=%0d got busy/free/idle=%b%b%b required=%b%b%b",
                             cyc, bus_busy_o, bus_free_o, bus_idle_o, mlv.busy, mlv.free, mlv.idle);
                end
            end
        end
    end

    int e, k, m, r, s, v, w, e2, x, y;

    initial begin
        rst_ni       = 1'b0;
        enable_i     = 1'b0;
        scl_i        = 1'b1;
        sda_i        = 1'b1;
        t_bus_free_i = CNTR_W'(10);
        t_hd_sta_i   = CNTR_W'(4);
        t_idle_i     = CNTR_W'(20);

        // Reset state
        push_lvl(2, 1'b0, 1'b0, 1'b0);
        tick(3);

        // Enable with lines high: free 12 cycles later, idle 21 cycles after that
        e = cyc;
        rst_ni   = 1'b1;
        enable_i = 1'b1;
        push_lvl(e + 11, 1'b0, 1'b0, 1'b0);
        push_lvl(e + 12, 1'b0, 1'b1, 1'b0);
        push_lvl(e + 32, 1'b0, 1'b1, 1'b0);
        push_lvl(e + 33, 1'b0, 1'b1, c_IDLE_EXP);
        wait_until(e + 36);

        // START with hold 4: pulse at k+6, busy from k+1, idle dropped at k+1
        k = cyc;
        push_lvl(k,     1'b0, 1'b1, c_IDLE_EXP);
        push_lvl(k + 1, 1'b1, 1'b0, 1'b0);
        push_lvl(k + 5, 1'b1, 1'b0, 1'b0);
        push_evt(k + 6, 4'b1000);
        push_lvl(k + 6, 1'b1, 1'b0, 1'b0);
        sda_i = 1'b0;
        wait_until(k + 7);
        scl_i = 1'b0;
        tick(1);
        sda_i = 1'b1;
        tick(1);
        scl_i = 1'b1;
        tick(1);

        // Repeated START aborted by SDA returning high: no pulse, stays busy
        m = cyc;
        t_hd_sta_i = CNTR_W'(5);
        push_lvl(m + 1, 1'b1, 1'b0, 1'b0);
        push_lvl(m + 3, 1'b1, 1'b0, 1'b0);
        push_lvl(m + 6, 1'b1, 1'b0, 1'b0);
        sda_i = 1'b0;
        tick(2);
        sda_i = 1'b1;
        wait_until(m + 8);

        // Qualified repeated START with hold 5: pulse at r+7
        r = cyc;
        push_evt(r + 7, 4'b0100);
        push_lvl(r + 7, 1'b1, 1'b0, 1'b0);
        sda_i = 1'b0;
        wait_until(r + 9);
        scl_i = 1'b0;
        tick(1);
        sda_i = 1'b1;
        tick(1);
        scl_i = 1'b1;
        tick(1);

        // STOP: SDA low under SCL low, SCL high, then SDA rise at s+3
        s = cyc;
        push_lvl(s + 3,  1'b1, 1'b0, 1'b0);
        push_evt(s + 4,  4'b0010);
        push_lvl(s + 4,  1'b0, 1'b0, 1'b0);
        push_lvl(s + 14, 1'b0, 1'b0, 1'b0);
        push_lvl(s + 15, 1'b0, 1'b1, 1'b0);
        push_lvl(s + 18, 1'b0, 1'b1, 1'b0);
        push_lvl(s + 19, 1'b0, 1'b1, 1'b0);
        push_lvl(s + 21, 1'b0, 1'b1, 1'b0);
        scl_i = 1'b0;
        tick(1);
        sda_i = 1'b0;
        tick(1);
        scl_i = 1'b1;
        tick(1);
        sda_i = 1'b1;
        // SDA fall together with SCL fall in FREE must not start a transfer
        wait_until(s + 17);
        scl_i = 1'b0;
        sda_i = 1'b0;
        wait_until(s + 20);
        scl_i = 1'b1;
        sda_i = 1'b1;
        wait_until(s + 22);

        // SCL drops 3 cycles into an 8-cycle hold: START plus violation
        v = cyc;
        t_hd_sta_i = CNTR_W'(8);
        push_lvl(v,     1'b0, 1'b1, 1'b0);
        push_lvl(v + 1, 1'b1, 1'b0, 1'b0);
        push_evt(v + 4, 4'b1001);
        push_lvl(v + 4, 1'b1, 1'b0, 1'b0);
        sda_i = 1'b0;
        wait_until(v + 3);
        scl_i = 1'b0;
        wait_until(v + 6);

        // Disable while busy: everything low next cycle
        w = cyc;
        push_lvl(w,     1'b1, 1'b0, 1'b0);
        push_lvl(w + 1, 1'b0, 1'b0, 1'b0);
        push_lvl(w + 2, 1'b0, 1'b0, 1'b0);
        enable_i = 1'b0;
        tick(1);
        scl_i = 1'b1;
        sda_i = 1'b1;
        tick(2);

        // Re-enable with an SDA glitch at e2+5: free delayed to e2+17
        e2 = cyc;
        push_lvl(e2 + 12, 1'b0, 1'b0, 1'b0);
        push_lvl(e2 + 16, 1'b0, 1'b0, 1'b0);
        push_lvl(e2 + 17, 1'b0, 1'b1, 1'b0);
        enable_i = 1'b1;
        wait_until(e2 + 5);
        sda_i = 1'b0;
        tick(1);
        sda_i = 1'b1;
        wait_until(e2 + 19);

        // Zero hold time: START pulse two cycles after the fall
        x = cyc;
        t_hd_sta_i = CNTR_W'(0);
        push_lvl(x + 1, 1'b1, 1'b0, 1'b0);
        push_evt(x + 2, 4'b1000);
        push_lvl(x + 2, 1'b1, 1'b0, 1'b0);
        push_lvl(x + 3, 1'b1, 1'b0, 1'b0);
        sda_i = 1'b0;
        wait_until(x + 4);

        // One-cycle reset mid-transfer: outputs clear at once, the following
        // SDA rise is not a STOP, and the bus must prove free again
        y = cyc;
        push_lvl(y,      1'b0, 1'b0, 1'b0);
        push_lvl(y + 1,  1'b0, 1'b0, 1'b0);
        push_lvl(y + 12, 1'b0, 1'b0, 1'b0);
        push_lvl(y + 13, 1'b0, 1'b1, 1'b0);
        push_lvl(y + 33, 1'b0, 1'b1, 1'b0);
        push_lvl(y + 34, 1'b0, 1'b1, c_IDLE_EXP);
        rst_ni = 1'b0;
        tick(1);
        rst_ni = 1'b1;
        tick(1);
        sda_i = 1'b1;
        wait_until(y + 37);

        n_checks++;
        if (evt_q.size() != 0) begin
            n_errors++;
            $display("FAIL pending_pulses got=%0d required=0", evt_q.size());
        end
        n_checks++;
        if (lvl_q.size() != 0) begin
            n_errors++;
            $display("FAIL pending_levels got=%0d required=0", lvl_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
